// File: rtl/sram_rec_pkg.sv
// Shared types and defaults for the SRAM audio recorder.
package sram_rec_pkg;
  localparam int SAMPLE_W_DEF = 16;
  localparam int ADDR_W_DEF   = 20;

  // Status codes double as the state encoding so o_state is the state register.
  localparam logic [2:0] CODE_IDLE  = 3'b001;
  localparam logic [2:0] CODE_ARM   = 3'b010;
  localparam logic [2:0] CODE_REC   = 3'b100;
  localparam logic [2:0] CODE_PAUSE = 3'b101;
  localparam logic [2:0] CODE_FULL  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = CODE_IDLE,
    ST_ARM   = CODE_ARM,
    ST_REC   = CODE_REC,
    ST_PAUSE = CODE_PAUSE,
    ST_FULL  = CODE_FULL
  } state_e;
endpackage

// File: rtl/i2s_rx_deser.sv
// Left-channel I2S deserializer: frame edge detect, MSB-first shift, one-cycle valid.
module i2s_rx_deser
  import sram_rec_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                i_bclk,
  input  logic                i_rst_n,
  input  logic                i_clear,
  input  logic                i_lrck,
  input  logic                i_dat,
  output logic                o_frame,
  output logic                o_valid,
  output logic [SAMPLE_W-1:0] o_sample
);
  localparam int CNT_W = $clog2(SAMPLE_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_W - 1);

  logic                lrck_q;
  logic                act_q, act_d;
  logic                vld_q, vld_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] sh_q, sh_d;

  assign o_frame  = lrck_q & ~i_lrck;
  assign o_valid  = vld_q;
  assign o_sample = sh_q;

  // The edge that sees the fall only arms; data starts one BCLK later.
  always_comb begin
    act_d = act_q;
    cnt_d = cnt_q;
    sh_d  = sh_q;
    vld_d = 1'b0;
    if (i_clear) begin
      act_d = 1'b0;
      cnt_d = '0;
    end else if (o_frame) begin
      act_d = 1'b1;
      cnt_d = '0;
    end else if (act_q) begin
      sh_d = {sh_q[SAMPLE_W-2:0], i_dat};
      if (cnt_q == LAST) begin
        act_d = 1'b0;
        vld_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrck_q <= 1'b0;
      act_q  <= 1'b0;
      vld_q  <= 1'b0;
      cnt_q  <= '0;
      sh_q   <= '0;
    end else begin
      lrck_q <= i_lrck;
      act_q  <= act_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
    end
  end
endmodule

// File: rtl/sram_recorder.sv
// Recorder control: FSM, SRAM address/length counters and single-cycle write strobe.
module sram_recorder
  import sram_rec_pkg::*;
#(
  parameter int                SAMPLE_W = SAMPLE_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] MAX_ADDR = '1
) (
  input  logic                i_bclk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_stop,
  input  logic                i_ADCLRCK,
  input  logic                i_ADCDAT,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [SAMPLE_W-1:0] o_SRAM_DQ,
  output logic                o_dq_oe,
  output logic                o_SRAM_WE_N,
  output logic [ADDR_W-1:0]   o_end_addr,
  output logic                o_full,
  output logic                o_rec_n,
  output logic [2:0]          o_state
);
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [SAMPLE_W-1:0] dq_q, dq_d;
  logic                oe_q, oe_d;
  logic                we_n_q, we_n_d;
  logic                full_q, full_d;

  logic                frame, vld, clear;
  logic [SAMPLE_W-1:0] sample;
  logic                wr_start, wr_done, hit_max;

  i2s_rx_deser #(.SAMPLE_W(SAMPLE_W)) u_deser (
    .i_bclk   (i_bclk),
    .i_rst_n  (i_rst_n),
    .i_clear  (clear),
    .i_lrck   (i_ADCLRCK),
    .i_dat    (i_ADCDAT),
    .o_frame  (frame),
    .o_valid  (vld),
    .o_sample (sample)
  );

  // Capture only runs while heading into ARM/REC; leaving them drops a partial sample.
  assign clear    = !(state_d == ST_ARM || state_d == ST_REC);
  assign wr_start = (state_q == ST_REC) && vld && i_enable && !i_stop;
  assign wr_done  = !we_n_q;
  assign hit_max  = wr_done && (addr_q == MAX_ADDR);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    end_d   = end_q;
    dq_d    = dq_q;
    oe_d    = oe_q;
    we_n_d  = we_n_q;
    full_d  = full_q;

    // An in-flight write always finishes, whatever the state does.
    if (wr_done) begin
      we_n_d = 1'b1;
      oe_d   = 1'b0;
      end_d  = addr_q + ADDR_W'(1);
      if (!hit_max) addr_d = addr_q + ADDR_W'(1);
    end
    if (wr_start) begin
      dq_d   = sample;
      oe_d   = 1'b1;
      we_n_d = 1'b0;
    end
    if (hit_max) full_d = 1'b1;

    if (!i_enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_start && !i_stop && !i_pause) begin
            state_d = ST_ARM;
            addr_d  = '0;
            end_d   = '0;
            full_d  = 1'b0;
          end
        end
        ST_ARM: begin
          if (i_stop)     state_d = ST_IDLE;
          else if (frame) state_d = ST_REC;
        end
        ST_REC: begin
          if (i_stop)       state_d = ST_IDLE;
          else if (hit_max) state_d = ST_FULL;
          else if (i_pause) state_d = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (i_stop)       state_d = ST_IDLE;
          else if (hit_max) state_d = ST_FULL;
          else if (i_pause) state_d = ST_ARM;
        end
        ST_FULL: begin
          if (i_stop) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      end_q   <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      we_n_q  <= we_n_d;
      full_q  <= full_d;
    end
  end

  assign o_addr      = addr_q;
  assign o_SRAM_DQ   = dq_q;
  assign o_dq_oe     = oe_q;
  assign o_SRAM_WE_N = we_n_q;
  assign o_end_addr  = end_q;
  assign o_full      = full_q;
  assign o_rec_n     = (state_q != ST_REC);
  assign o_state     = state_q;
endmodule

// File: tb/tb_sram_recorder.sv
// Scoreboarded bench: expected SRAM writes queued per frame, checked by per-DUT write monitors.
module tb_sram_recorder;
  typedef struct {
    int          cyc;
    logic [19:0] a;
    logic [15:0] d;
  } exp_t;

  logic bclk = 1'b0;
  logic rst_n, start, pause, stop, lrck, dat;
  logic [1:0]  en;
  logic [19:0] addr [2];
  logic [19:0] endad[2];
  logic [15:0] dq   [2];
  logic [2:0]  st   [2];
  logic [1:0]  oe, wen, full, recn;

  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  int   cur = 0;
  exp_t expq[2][$];

  always #5 bclk = ~bclk;
  always @(posedge bclk) cyc <= cyc + 1;

  sram_recorder dut0 (
    .i_bclk(bclk), .i_rst_n(rst_n), .i_enable(en[0]), .i_start(start), .i_pause(pause),
    .i_stop(stop), .i_ADCLRCK(lrck), .i_ADCDAT(dat), .o_addr(addr[0]), .o_SRAM_DQ(dq[0]),
    .o_dq_oe(oe[0]), .o_SRAM_WE_N(wen[0]), .o_end_addr(endad[0]), .o_full(full[0]),
    .o_rec_n(recn[0]), .o_state(st[0])
  );

  sram_recorder #(.MAX_ADDR(20'h00003)) dut1 (
    .i_bclk(bclk), .i_rst_n(rst_n), .i_enable(en[1]), .i_start(start), .i_pause(pause),
    .i_stop(stop), .i_ADCLRCK(lrck), .i_ADCDAT(dat), .o_addr(addr[1]), .o_SRAM_DQ(dq[1]),
    .o_dq_oe(oe[1]), .o_SRAM_WE_N(wen[1]), .o_end_addr(endad[1]), .o_full(full[1]),
    .o_rec_n(recn[1]), .o_state(st[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic prev_we = 1'b1;
    always @(posedge bclk) begin
      exp_t e;
      #1;
      if (wen[g] === 1'b0) begin
        chk($sformatf("dut%0d_we_width", g), {31'd0, prev_we}, 32'd1);
        if (expq[g].size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL dut%0d_unexpected_write: addr %0h data %0h at cycle %0d", g, addr[g], dq[g], cyc);
        end else begin
          e = expq[g].pop_front();
          chk($sformatf("dut%0d_we_cycle", g), cyc, e.cyc);
          chk($sformatf("dut%0d_wr_addr", g), {12'd0, addr[g]}, {12'd0, e.a});
          chk($sformatf("dut%0d_wr_data", g), {16'd0, dq[g]}, {16'd0, e.d});
          chk($sformatf("dut%0d_wr_oe", g), {31'd0, oe[g]}, 32'd1);
        end
      end
      prev_we = wen[g];
    end
  end

  // One I2S frame: 18 BCLKs low (delay bit + 16 data + pad), 18 high. A short
  // frame rises after nbits and returns so the next frame falls mid-capture.
  task automatic send_frame(input logic [15:0] s, input int nbits, input bit wr, input logic [19:0] a);
    exp_t e;
    @(negedge bclk);
    if (wr) begin
      e.cyc = cyc + 18;
      e.a   = a;
      e.d   = s;
      expq[cur].push_back(e);
    end
    lrck = 1'b0;
    dat  = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge bclk);
      if (nbits < 16 && c == nbits + 1) begin
        lrck = 1'b1;
        dat  = 1'b0;
        return;
      end
      dat = (c <= 16) ? s[16-c] : 1'b0;
    end
    for (int c = 0; c < 18; c++) begin
      @(negedge bclk);
      lrck = 1'b1;
      dat  = c[0];
    end
  endtask

  task automatic pulse(input bit p_start, input bit p_pause, input bit p_stop);
    @(negedge bclk);
    start = p_start;
    pause = p_pause;
    stop  = p_stop;
    @(negedge bclk);
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    lrck = 1'b1; dat = 1'b0; en = 2'b01;
    repeat (3) @(negedge bclk);
    chk("rst_state", {29'd0, st[0]}, 32'h1);
    chk("rst_addr", {12'd0, addr[0]}, 32'h0);
    chk("rst_dq", {16'd0, dq[0]}, 32'h0);
    chk("rst_oe", {31'd0, oe[0]}, 32'h0);
    chk("rst_we_n", {31'd0, wen[0]}, 32'h1);
    chk("rst_end", {12'd0, endad[0]}, 32'h0);
    chk("rst_full", {31'd0, full[0]}, 32'h0);
    chk("rst_rec_n", {31'd0, recn[0]}, 32'h1);
    rst_n = 1'b1;
    repeat (2) @(negedge bclk);

    // Three frames to addresses 0..2.
    pulse(1, 0, 0);
    chk("arm_state", {29'd0, st[0]}, 32'h2);
    send_frame(16'hA5C3, 16, 1, 20'd0);
    send_frame(16'h0001, 16, 1, 20'd1);
    send_frame(16'hFFFF, 16, 1, 20'd2);
    chk("rec_state", {29'd0, st[0]}, 32'h4);
    chk("rec_rec_n", {31'd0, recn[0]}, 32'h0);
    chk("three_end", {12'd0, endad[0]}, 32'h3);
    chk("three_addr", {12'd0, addr[0]}, 32'h3);
    pulse(0, 0, 1);
    chk("stop_state", {29'd0, st[0]}, 32'h1);
    chk("stop_end_kept", {12'd0, endad[0]}, 32'h3);

    // Aborted partial frame, then a full one at address 0.
    pulse(1, 0, 0);
    chk("restart_end", {12'd0, endad[0]}, 32'h0);
    send_frame(16'hBEEF, 7, 0, 20'd0);
    send_frame(16'h1234, 16, 1, 20'd0);
    chk("abort_end", {12'd0, endad[0]}, 32'h1);
    pulse(0, 0, 1);

    // Pause mid-capture of frame 2, resume four frames later.
    pulse(1, 0, 0);
    send_frame(16'h1111, 16, 1, 20'd0);
    fork
      send_frame(16'h2222, 16, 0, 20'd0);
      begin
        repeat (5) @(negedge bclk);
        pause = 1'b1;
        @(negedge bclk);
        pause = 1'b0;
      end
    join
    chk("pause_state", {29'd0, st[0]}, 32'h5);
    for (int i = 0; i < 4; i++) send_frame(16'h3333 + 16'(i), 16, 0, 20'd0);
    chk("pause_end", {12'd0, endad[0]}, 32'h1);
    pulse(0, 1, 0);
    chk("resume_state", {29'd0, st[0]}, 32'h2);
    send_frame(16'h5555, 16, 1, 20'd1);
    chk("resume_end", {12'd0, endad[0]}, 32'h2);

    // Stop and pause together: stop wins.
    pulse(0, 1, 1);
    chk("stop_pause_state", {29'd0, st[0]}, 32'h1);
    chk("stop_pause_end", {12'd0, endad[0]}, 32'h2);

    // Small memory: four writes then FULL.
    en = 2'b10;
    cur = 1;
    @(negedge bclk);
    chk("full_idle", {29'd0, st[1]}, 32'h1);
    pulse(1, 0, 0);
    for (int i = 0; i < 6; i++) send_frame(16'hC000 + 16'(i), 16, i < 4, 20'(i));
    chk("full_state", {29'd0, st[1]}, 32'h7);
    chk("full_flag", {31'd0, full[1]}, 32'h1);
    chk("full_end", {12'd0, endad[1]}, 32'h4);
    chk("full_rec_n", {31'd0, recn[1]}, 32'h1);
    pulse(0, 0, 1);
    chk("full_stop_state", {29'd0, st[1]}, 32'h1);
    chk("full_stop_flag", {31'd0, full[1]}, 32'h1);
    pulse(1, 0, 0);
    chk("full_clear_flag", {31'd0, full[1]}, 32'h0);

    // Reset asserted while WE_N is low.
    en = 2'b01;
    cur = 0;
    pulse(1, 0, 0);
    fork
      send_frame(16'hABCD, 16, 1, 20'd0);
      begin
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
          @(posedge bclk);
          #1;
          if (wen[0] === 1'b0) seen = 1'b1;
        end
        chk("rst_wr_seen", {31'd0, seen}, 32'h1);
        @(negedge bclk);
        rst_n = 1'b0;
        #1;
        chk("rst_async_we_n", {31'd0, wen[0]}, 32'h1);
        chk("rst_async_addr", {12'd0, addr[0]}, 32'h0);
        chk("rst_async_oe", {31'd0, oe[0]}, 32'h0);
        chk("rst_async_state", {29'd0, st[0]}, 32'h1);
      end
    join
    send_frame(16'h7777, 16, 0, 20'd0);
    rst_n = 1'b1;
    send_frame(16'h8888, 16, 0, 20'd0);
    chk("post_rst_end", {12'd0, endad[0]}, 32'h0);

    repeat (4) @(negedge bclk);
    chk("q0_drained", expq[0].size(), 32'd0);
    chk("q1_drained", expq[1].size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
